// File: rtl/lock_output_error_monitor_if.sv
// Vector bus from the locked adder into the error monitor: operands, result and valid.
interface lock_output_error_monitor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             vld_i;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic [WIDTH:0]   result_i;

  modport master (output vld_i, add1_i, add2_i, result_i);
  modport slave  (input  vld_i, add1_i, add2_i, result_i);
endinterface

// File: rtl/lock_output_error_monitor.sv
// Windowed output-corruption monitor for a locked adder: counts mismatches, Hamming sum and max.
// Optional first-mismatch capture ports are enabled by defining LOCK_ERR_FIRST_CAPTURE_EN.
module lock_output_error_monitor #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned KEY_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     num_vec_i,
  input  logic [KEY_WIDTH-1:0]     keyinput_i,
  lock_output_error_monitor_if.slave vec_if,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o,
  output logic [ACC_WIDTH-1:0]     hd_sum_o,
  output logic [4:0]               max_hd_o,
  output logic [KEY_WIDTH-1:0]     key_o
`ifdef LOCK_ERR_FIRST_CAPTURE_EN
  ,
  output logic                     first_err_vld_o,
  output logic [CNT_WIDTH-1:0]     first_err_idx_o,
  output logic [WIDTH-1:0]         first_err_a_o,
  output logic [WIDTH-1:0]         first_err_b_o,
  output logic [WIDTH:0]           first_err_res_o
`endif
);

  localparam int unsigned RES_W     = WIDTH + 1;
  localparam int unsigned ACC_EXT_W = ACC_WIDTH + 1;
  localparam int unsigned HD_W      = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_drain2;
  logic                 r_busy, r_done;
  logic [CNT_WIDTH-1:0] r_cnt, r_num_vec;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 w_start_acc, w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  logic                 r_v1;
  logic [RES_W-1:0]     r_diff;
  logic [RES_W-1:0]     w_golden;
  logic [HD_W-1:0]      w_hd;
  logic [ACC_EXT_W-1:0] w_hd_ext;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [ACC_WIDTH-1:0] r_hd_sum;
  logic [HD_W-1:0]      r_max_hd;

  assign w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
  assign w_golden  = {1'b0, vec_if.add1_i} + {1'b0, vec_if.add2_i};

  // Next-state and window-control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          w_state_nxt = (num_vec_i == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (vec_if.vld_i) begin
          w_accept = 1'b1;
          if (w_cnt_nxt == r_num_vec) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (r_drain2) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_drain2  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_num_vec <= '0;
      r_key     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_drain2 <= (r_state == ST_DRAIN) && !r_drain2;
      r_busy   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done   <= (w_state_nxt == ST_DONE);
      if (w_start_acc) begin
        r_cnt     <= '0;
        r_num_vec <= num_vec_i;
        r_key     <= keyinput_i;
      end else if (w_accept) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  // S1: golden sum compare
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1   <= 1'b0;
      r_diff <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) r_diff <= vec_if.result_i ^ w_golden;
    end
  end

  always_comb begin
    w_hd = '0;
    for (int i = 0; i < RES_W; i++) w_hd = w_hd + HD_W'(r_diff[i]);
  end

  assign w_hd_ext = {1'b0, r_hd_sum} + ACC_EXT_W'(w_hd);

  // S2: saturating accumulators
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
      r_hd_sum  <= '0;
      r_max_hd  <= '0;
    end else if (w_start_acc) begin
      r_err_cnt <= '0;
      r_hd_sum  <= '0;
      r_max_hd  <= '0;
    end else if (r_v1) begin
      if ((|r_diff) && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
      r_hd_sum <= w_hd_ext[ACC_WIDTH] ? '1 : w_hd_ext[ACC_WIDTH-1:0];
      if (w_hd > r_max_hd) r_max_hd <= w_hd;
    end
  end

`ifdef LOCK_ERR_FIRST_CAPTURE_EN
  logic [CNT_WIDTH-1:0] r_idx1;
  logic [WIDTH-1:0]     r_a1, r_b1;
  logic [RES_W-1:0]     r_res1;
  logic                 r_fe_vld;
  logic [CNT_WIDTH-1:0] r_fe_idx;
  logic [WIDTH-1:0]     r_fe_a, r_fe_b;
  logic [RES_W-1:0]     r_fe_res;

  // Vector index and payload travel alongside S1 so S2 can latch the first mismatch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx1 <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_res1 <= '0;
    end else if (w_accept) begin
      r_idx1 <= r_cnt;
      r_a1   <= vec_if.add1_i;
      r_b1   <= vec_if.add2_i;
      r_res1 <= vec_if.result_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_acc) begin
      r_fe_vld <= 1'b0;
      r_fe_idx <= '0;
      r_fe_a   <= '0;
      r_fe_b   <= '0;
      r_fe_res <= '0;
    end else if (r_v1 && (|r_diff) && !r_fe_vld) begin
      r_fe_vld <= 1'b1;
      r_fe_idx <= r_idx1;
      r_fe_a   <= r_a1;
      r_fe_b   <= r_b1;
      r_fe_res <= r_res1;
    end
  end

  assign first_err_vld_o = r_fe_vld;
  assign first_err_idx_o = r_fe_idx;
  assign first_err_a_o   = r_fe_a;
  assign first_err_b_o   = r_fe_b;
  assign first_err_res_o = r_fe_res;
`endif

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_cnt_o = r_err_cnt;
  assign hd_sum_o  = r_hd_sum;
  assign max_hd_o  = r_max_hd;
  assign key_o     = r_key;

endmodule

// File: tb/tb_lock_output_error_monitor.sv
// Bench for lock_output_error_monitor: window-level reference model plus directed vectors.
module tb_lock_output_error_monitor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] num_vec_i = '0;
  logic [31:0] keyinput_i = '0;
  logic        busy_o, done_o;
  logic [15:0] err_cnt_o;
  logic [23:0] hd_sum_o;
  logic [4:0]  max_hd_o;
  logic [31:0] key_o;
`ifdef LOCK_ERR_FIRST_CAPTURE_EN
  logic        first_err_vld_o;
  logic [15:0] first_err_idx_o;
  logic [15:0] first_err_a_o, first_err_b_o;
  logic [16:0] first_err_res_o;
`endif

  lock_output_error_monitor_if #(.WIDTH(16)) vif ();

  lock_output_error_monitor dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .num_vec_i  (num_vec_i),
    .keyinput_i (keyinput_i),
    .vec_if     (vif),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_cnt_o  (err_cnt_o),
    .hd_sum_o   (hd_sum_o),
    .max_hd_o   (max_hd_o),
    .key_o      (key_o)
`ifdef LOCK_ERR_FIRST_CAPTURE_EN
    ,
    .first_err_vld_o (first_err_vld_o),
    .first_err_idx_o (first_err_idx_o),
    .first_err_a_o   (first_err_a_o),
    .first_err_b_o   (first_err_b_o),
    .first_err_res_o (first_err_res_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a window opens on an honoured start at edge p, accepts the next
  // N valid edges, and with the last accept at edge e it is busy through e+1,
  // signals done right after e+2, and honours a new start from e+4 on.
  int          cyc = 0;
  bit          win = 0;
  int          m_n, m_acc, m_end;
  int          m_err = 0, m_hd = 0, m_max = 0;
  logic [31:0] m_key = '0;
  bit          m_fe_vld = 0;
  int          m_fe_idx = 0;
  logic [15:0] m_fe_a = '0, m_fe_b = '0;
  logic [16:0] m_fe_res = '0;

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
    if (rst_i) begin
      win = 0; m_err = 0; m_hd = 0; m_max = 0; m_key = '0;
      m_fe_vld = 0; m_fe_idx = 0; m_fe_a = '0; m_fe_b = '0; m_fe_res = '0;
    end else if ((!win || (m_end >= 0 && cyc >= m_end + 4)) && start_i) begin
      win = 1; m_n = int'(num_vec_i); m_acc = 0;
      m_end = (m_n == 0) ? cyc : -1;
      m_err = 0; m_hd = 0; m_max = 0; m_key = keyinput_i;
      m_fe_vld = 0; m_fe_idx = 0; m_fe_a = '0; m_fe_b = '0; m_fe_res = '0;
    end else if (win && m_end < 0 && vif.vld_i) begin
      int gold, h;
      gold = int'(vif.add1_i) + int'(vif.add2_i);
      h = $countones(gold ^ int'(vif.result_i));
      if (h != 0) begin
        if (m_err < 65535) m_err = m_err + 1;
        if (!m_fe_vld) begin
          m_fe_vld = 1; m_fe_idx = m_acc;
          m_fe_a = vif.add1_i; m_fe_b = vif.add2_i; m_fe_res = vif.result_i;
        end
      end
      m_hd = (m_hd + h > 24'hFFFFFF) ? 24'hFFFFFF : m_hd + h;
      if (h > m_max) m_max = h;
      m_acc = m_acc + 1;
      if (m_acc == m_n) m_end = cyc;
    end
  end

  // Compare process: handshake every cycle, results whenever the window is not running
  initial forever begin
    bit e_busy, e_done;
    @(negedge clk_i);
    if (cyc > 0) begin
      e_busy = win && (m_end < 0 || cyc <= m_end + 1);
      e_done = win && m_end >= 0 && cyc == m_end + 2;
      chk("busy", 64'(busy_o), 64'(e_busy));
      chk("done", 64'(done_o), 64'(e_done));
      if (!e_busy) begin
        chk("err_cnt", 64'(err_cnt_o), 64'(m_err));
        chk("hd_sum", 64'(hd_sum_o), 64'(m_hd));
        chk("max_hd", 64'(max_hd_o), 64'(m_max));
        chk("key", 64'(key_o), 64'(m_key));
`ifdef LOCK_ERR_FIRST_CAPTURE_EN
        chk("fe_vld", 64'(first_err_vld_o), 64'(m_fe_vld));
        chk("fe_idx", 64'(first_err_idx_o), 64'(m_fe_idx));
        chk("fe_a", 64'(first_err_a_o), 64'(m_fe_a));
        chk("fe_b", 64'(first_err_b_o), 64'(m_fe_b));
        chk("fe_res", 64'(first_err_res_o), 64'(m_fe_res));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_win(input logic [15:0] n, input logic [31:0] key);
    start_i = 1'b1; num_vec_i = n; keyinput_i = key;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
    vif.vld_i = 1'b1; vif.add1_i = a; vif.add2_i = b; vif.result_i = r;
    tick();
    vif.vld_i = 1'b0;
  endtask

  // Returns cycles from the last driven cycle until done_o is seen; bounded
  task automatic wait_done(output int lat);
    int n = 0;
    while (!done_o && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_o), 64'(1));
    lat = n + 1;
  endtask

  task automatic chk_res(input string tag, input int err, input int hd, input int mx,
                         input logic [31:0] key);
    chk({tag, "_err"}, 64'(err_cnt_o), 64'(err));
    chk({tag, "_hd"}, 64'(hd_sum_o), 64'(hd));
    chk({tag, "_max"}, 64'(max_hd_o), 64'(mx));
    chk({tag, "_key"}, 64'(key_o), 64'(key));
  endtask

  initial begin
    int lat;
    vif.vld_i = 1'b0; vif.add1_i = '0; vif.add2_i = '0; vif.result_i = '0;
    repeat (3) tick();
    chk_res("reset", 0, 0, 0, 32'h0);
    rst_i = 1'b0;
    tick();

    // 1: window of 4, all correct
    start_win(16'd4, 32'hE435B5EE);
    repeat (4) send(16'h0001, 16'h0001, 17'h00002);
    wait_done(lat);
    chk_res("t1", 0, 0, 0, 32'hE435B5EE);
    tick(); tick();

    // 2: single-bit error, done latency from the valid cycle
    start_win(16'd1, 32'h00000001);
    send(16'h0001, 16'h0001, 17'h00003);
    wait_done(lat);
    chk("t2_lat", 64'(lat), 64'(3));
    chk_res("t2", 1, 1, 1, 32'h00000001);
    chk("t2_model_hd", 64'(m_hd), 64'(1));
    tick(); tick();

    // 3: carry kept, maximum distance
    start_win(16'd2, 32'h00000002);
    send(16'hFFFF, 16'h0001, 17'h10000);
    send(16'h0000, 16'h0000, 17'h1FFFF);
    wait_done(lat);
    chk_res("t3", 1, 17, 17, 32'h00000002);
    chk("t3_model_max", 64'(m_max), 64'(17));
    tick(); tick();

    // 4a: gaps, start in RUN ignored, valid after last vector ignored
    start_win(16'd3, 32'h11112222);
    send(16'h0002, 16'h0003, 17'h00005);
    tick();
    start_i = 1'b1; num_vec_i = 16'd0; keyinput_i = 32'hDEADBEEF;
    tick();
    start_i = 1'b0;
    send(16'h0010, 16'h0001, 17'h00010);
    tick(); tick();
    send(16'h00FF, 16'h0001, 17'h00000);
    send(16'h0000, 16'h0000, 17'h1FFFF);
    wait_done(lat);
    chk_res("t4a", 2, 2, 1, 32'h11112222);
    tick(); tick();

    // 4b: empty window
    start_win(16'd0, 32'h0BADF00D);
    wait_done(lat);
    chk("t4b_lat", 64'(lat), 64'(3));
    chk_res("t4b", 0, 0, 0, 32'h0BADF00D);
    tick(); tick();

    // 5: reset mid-RUN abandons the window, then a clean restart
    start_win(16'd5, 32'hAAAA5555);
    send(16'h0001, 16'h0001, 17'h00000);
    send(16'h0002, 16'h0002, 17'h1FFFF);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_busy", 64'(busy_o), 64'(0));
    chk_res("t5_rst", 0, 0, 0, 32'h0);
    repeat (6) tick();
    start_win(16'd2, 32'h0F0F0F0F);
    send(16'h1111, 16'h2222, 17'h03333);
    send(16'h8000, 16'h8000, 17'h10000);
    wait_done(lat);
    chk_res("t5", 0, 0, 0, 32'h0F0F0F0F);
    tick(); tick();

`ifdef LOCK_ERR_FIRST_CAPTURE_EN
    // 6: first mismatch captured, later ones do not overwrite
    start_win(16'd4, 32'h12345678);
    send(16'h0001, 16'h0001, 17'h00002);
    send(16'h0003, 16'h0004, 17'h00007);
    send(16'h1234, 16'h0001, 17'h01236);
    send(16'h0000, 16'h0000, 17'h00001);
    wait_done(lat);
    chk_res("t6", 2, 3, 2, 32'h12345678);
    chk("t6_fe_vld", 64'(first_err_vld_o), 64'(1));
    chk("t6_fe_idx", 64'(first_err_idx_o), 64'(2));
    chk("t6_fe_a", 64'(first_err_a_o), 64'(16'h1234));
    chk("t6_fe_b", 64'(first_err_b_o), 64'(16'h0001));
    chk("t6_fe_res", 64'(first_err_res_o), 64'(17'h01236));
    tick(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
